// File: rtl/vector_recorder_if.sv
// Control, sample and readback bundle for vector_recorder.
// master drives the stimulus side; slave is the recorder itself.
interface vector_recorder_if #(
    parameter int unsigned VEC_W  = 3,
    parameter int unsigned ADDR_W = 5
);
    logic              start;
    logic              trig;
    logic              stop;
    logic [ADDR_W:0]   limit;
    logic [VEC_W-1:0]  sample_in;
    logic [ADDR_W-1:0] rd_addr;
    logic [VEC_W-1:0]  rd_data;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic              full;

    modport master (
        output start, trig, stop, limit, sample_in, rd_addr,
        input  rd_data, count, busy, done, full
    );

    modport slave (
        input  start, trig, stop, limit, sample_in, rd_addr,
        output rd_data, count, busy, done, full
    );
endinterface

// File: rtl/vector_recorder.sv
// Records one VEC_W-bit vector per capture strobe into an internal memory.
// The control FSM runs arm -> trigger -> capture -> done; readback is registered.
module vector_recorder #(
    parameter int unsigned VEC_W  = 3,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned PERIOD = 1
) (
    input logic              clk,
    input logic              reset,
    vector_recorder_if.slave bus
);
    localparam int unsigned       PACE_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_C     = (ADDR_W + 1)'(1);
    localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'(PERIOD - 1);

    typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   limit_q, limit_d;
    logic [PACE_W-1:0] pace_q, pace_d;
    logic [VEC_W-1:0]  rd_data_q;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [VEC_W-1:0]  mem [DEPTH];

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        pace_d  = pace_q;
        wr_en   = 1'b0;
        wr_addr = count_q[ADDR_W-1:0];
        case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d = StArmed;
                    count_d = '0;
                    pace_d  = '0;
                    limit_d = (bus.limit == '0 || bus.limit > DEPTH_C) ? DEPTH_C : bus.limit;
                end
            end
            StArmed: begin
                if (bus.stop) begin
                    state_d = StDone;
                    count_d = '0;
                end else if (bus.trig) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    count_d = ONE_C;
                    pace_d  = '0;
                    // A limit of one is satisfied by the trigger write alone.
                    state_d = (limit_q == ONE_C) ? StDone : StCapture;
                end
            end
            StCapture: begin
                if (bus.stop) begin
                    state_d = StDone;
                end else if (pace_q == PACE_LAST) begin
                    pace_d  = '0;
                    wr_en   = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_d == limit_q) begin
                        state_d = StDone;
                    end
                end else begin
                    pace_d = pace_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            count_q   <= '0;
            limit_q   <= DEPTH_C;
            pace_q    <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
            pace_q    <= pace_d;
            rd_data_q <= mem[bus.rd_addr];
        end
    end

    // Vector memory is deliberately not reset so captures survive a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= bus.sample_in;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.count   = count_q;
    assign bus.busy    = (state_q == StArmed) || (state_q == StCapture);
    assign bus.done    = (state_q == StDone);
    assign bus.full    = (count_q == DEPTH_C);
endmodule

// File: tb/tb_vector_recorder.sv
// Directed bench for vector_recorder: PERIOD=1 and PERIOD=4 instances, status
// checks inline and readback data checked through an expected-value queue.
module tb_vector_recorder;
    localparam int VEC_W  = 3;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    vector_recorder_if #(.VEC_W(VEC_W), .ADDR_W(ADDR_W)) if1 ();
    vector_recorder_if #(.VEC_W(VEC_W), .ADDR_W(ADDR_W)) if4 ();

    vector_recorder #(.VEC_W(VEC_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .PERIOD(1)) u_p1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    vector_recorder #(.VEC_W(VEC_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .PERIOD(4)) u_p4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit               sel;
        logic [VEC_W-1:0] data;
        string            name;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    logic    rd_req   = 1'b0;
    logic    rd_sel   = 1'b0;
    logic    mon_pend = 1'b0;
    logic    mon_sel  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Readback request: expected data queued now, compared one clock later.
    task automatic rd(input bit sel, input int addr, input int exp, input string name);
        rd_sel = sel;
        if (sel) if4.rd_addr = 5'(addr);
        else     if1.rd_addr = 5'(addr);
        rd_req = 1'b1;
        rd_q.push_back('{sel, 3'(exp), name});
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    always @(posedge clk) begin
        mon_pend <= rd_req;
        mon_sel  <= rd_sel;
    end

    always @(negedge clk) begin
        rd_exp_t e;
        if (mon_pend) begin
            if (rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL readback: data presented with no expected entry");
            end else begin
                e = rd_q.pop_front();
                chk(e.name, mon_sel ? 32'(if4.rd_data) : 32'(if1.rd_data), 32'(e.data));
            end
        end
    end

    initial begin
        if1.start = 0; if1.trig = 0; if1.stop = 0; if1.limit = '0;
        if1.sample_in = '0; if1.rd_addr = '0;
        if4.start = 0; if4.trig = 0; if4.stop = 0; if4.limit = '0;
        if4.sample_in = '0; if4.rd_addr = '0;
        repeat (3) @(negedge clk);

        // Reset state, sampled while reset is still held
        chk("rst_busy1",  if1.busy, 0);
        chk("rst_done1",  if1.done, 0);
        chk("rst_full1",  if1.full, 0);
        chk("rst_count1", if1.count, 0);
        chk("rst_rdata1", if1.rd_data, 0);
        chk("rst_busy4",  if4.busy, 0);
        chk("rst_count4", if4.count, 0);
        reset = 1'b1;
        @(negedge clk);

        // PERIOD=4, limit=3: writes at t0, t0+4, t0+8
        if4.limit = 3; if4.start = 1;
        @(negedge clk);
        if4.start = 0;
        chk("p4_armed", if4.busy, 1);
        for (int c = 0; c <= 8; c++) begin
            if4.trig = (c == 0);
            if4.sample_in = 3'((c + 2) % 8);
            @(negedge clk);
            if (c == 0) chk("p4_cnt_c0", if4.count, 1);
            if (c == 3) chk("p4_cnt_c3", if4.count, 1);
            if (c == 4) chk("p4_cnt_c4", if4.count, 2);
            if (c == 7) chk("p4_done_c7", if4.done, 0);
        end
        if4.trig = 0;
        chk("p4_done", if4.done, 1);
        chk("p4_count", if4.count, 3);
        chk("p4_busy", if4.busy, 0);
        rd(1, 0, 2, "p4_rd0");
        rd(1, 1, 6, "p4_rd1");
        rd(1, 2, 2, "p4_rd2");

        // PERIOD=1, limit=24, sample = k%8
        if1.limit = 24; if1.start = 1;
        @(negedge clk);
        if1.start = 0;
        chk("p1_armed_busy", if1.busy, 1);
        chk("p1_armed_count", if1.count, 0);
        for (int k = 0; k < 24; k++) begin
            if1.trig = (k == 0);
            if1.sample_in = 3'(k % 8);
            if (k == 23) begin
                chk("p1_done_early", if1.done, 0);
                chk("p1_count_23", if1.count, 23);
            end
            @(negedge clk);
        end
        if1.trig = 0;
        chk("p1_done", if1.done, 1);
        chk("p1_count", if1.count, 24);
        chk("p1_full", if1.full, 0);
        chk("p1_busy", if1.busy, 0);
        for (int k = 0; k < 24; k++) rd(0, k, k % 8, "p1_rd");

        // limit=0 means DEPTH; a start mid-capture must be ignored
        if1.limit = 0; if1.start = 1;
        @(negedge clk);
        if1.start = 0;
        for (int k = 0; k < 32; k++) begin
            if1.trig = (k == 0);
            if1.start = (k == 10);
            if1.sample_in = 3'((k * 3 + 1) % 8);
            @(negedge clk);
        end
        if1.trig = 0; if1.start = 0;
        chk("full_done", if1.done, 1);
        chk("full_full", if1.full, 1);
        chk("full_count", if1.count, 32);
        if1.trig = 1; if1.sample_in = 7;
        repeat (3) @(negedge clk);
        if1.trig = 0;
        chk("full_count_held", if1.count, 32);
        rd(0, 0, 1, "full_rd0");
        rd(0, 5, 0, "full_rd5");
        rd(0, 10, 7, "full_rd10");
        rd(0, 24, 1, "full_rd24");
        rd(0, 31, 6, "full_rd31");

        // start in DONE rearms and clears status
        if1.limit = 24; if1.start = 1;
        @(negedge clk);
        if1.start = 0;
        chk("rearm_busy", if1.busy, 1);
        chk("rearm_done", if1.done, 0);
        chk("rearm_full", if1.full, 0);
        chk("rearm_count", if1.count, 0);

        // stop beats trig in ARMED
        if1.stop = 1; if1.trig = 1; if1.sample_in = 5;
        @(negedge clk);
        if1.stop = 0; if1.trig = 0;
        chk("stop_armed_done", if1.done, 1);
        chk("stop_armed_count", if1.count, 0);
        rd(0, 0, 1, "stop_armed_nowrite");

        // stop in CAPTURE after 5 writes drops the 6th
        if1.start = 1;
        @(negedge clk);
        if1.start = 0;
        for (int k = 0; k < 6; k++) begin
            if1.trig = (k == 0);
            if1.stop = (k == 5);
            if1.sample_in = 3'(7 - k);
            @(negedge clk);
        end
        if1.stop = 0; if1.trig = 0;
        chk("stop_cap_done", if1.done, 1);
        chk("stop_cap_count", if1.count, 5);
        rd(0, 4, 3, "stop_cap_rd4");
        rd(0, 5, 0, "stop_cap_no6th");

        // Reset mid-capture at count=7
        if1.start = 1;
        @(negedge clk);
        if1.start = 0;
        if1.rd_addr = 5'd20;
        for (int k = 0; k < 7; k++) begin
            if1.trig = (k == 0);
            if1.sample_in = 3'((k + 4) % 8);
            @(negedge clk);
        end
        if1.trig = 0;
        chk("mid_count", if1.count, 7);
        chk("mid_busy", if1.busy, 1);
        chk("mid_rdata", if1.rd_data, 5);
        #2 reset = 1'b0;
        #1;
        chk("async_busy", if1.busy, 0);
        chk("async_count", if1.count, 0);
        chk("async_rdata", if1.rd_data, 0);
        chk("async_done", if1.done, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", if1.busy, 0);

        // Fresh run after reset, memory outside it retained
        if1.limit = 4; if1.start = 1;
        @(negedge clk);
        if1.start = 0;
        for (int k = 0; k < 4; k++) begin
            if1.trig = (k == 0);
            if1.sample_in = 3'(k + 1);
            @(negedge clk);
        end
        if1.trig = 0;
        chk("rerun_done", if1.done, 1);
        chk("rerun_count", if1.count, 4);
        for (int k = 0; k < 4; k++) rd(0, k, k + 1, "rerun_rd");
        rd(0, 6, 2, "partial_kept");
        rd(0, 10, 7, "mem_kept");

        repeat (3) @(negedge clk);
        checks++;
        if (rd_q.size() != 0) begin
            failures++;
            $display("FAIL readback_drain: got %0d pending expected 0", rd_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
